axil_lite_master: RTL and testbench

- AXI-Lite master (initiator) that turns single register read/write commands from local control logic into AXI-Lite transactions toward memory-mapped slaves such as the GPIO peripheral.
- One outstanding transaction at a time; command/response valid-ready interface on the local side.
- A watchdog counter flags a stalled slave without breaking AXI handshake rules.

---
 rtl/axil_lite_master.sv | 235 +++++++++++++++++++++++
 tb/tb_axil_lite_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_lite_master.sv
// AXI-Lite master: turns single local read/write commands into AXI-Lite
// transactions. At most one transaction is outstanding, and a watchdog flags
// a stalled slave.
module axil_lite_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // local command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    // local response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic                  busy,
    output logic                  err_timeout,
    // AXI-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    // AXI-Lite read address / data
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [RESP_W-1:0]     resp_q, resp_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, channel handshakes, response capture and watchdog
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        write_d     = write_q;
        err_d       = err_q;
        wd_cnt_d    = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    write_d = cmd_write;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently, in either order
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    resp_d      = M_AXI_BRESP;
                    rdata_d     = '0;
                    write_d     = 1'b1;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    rdata_d     = M_AXI_RDATA;
                    resp_d      = M_AXI_RRESP;
                    write_d     = 1'b0;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog only observes slave-facing phases; it never aborts them
        if ((state_d != state_q) || (state_q == IDLE) || (state_q == RESP)) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
        if ((TIMEOUT_CYCLES != 0) && (wd_cnt_d == WD_MAX)) begin
            err_d = 1'b1;
        end
    end

    // Datapath and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            write_q     <= write_d;
            err_q       <= err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_write     = write_q;
    assign err_timeout   = err_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_lite_master.sv
// Directed bench for axil_lite_master with a cycle-stepped AXI-Lite slave.
module tb_axil_lite_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, busy, err_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_fail   = 0;

    // results of the last run_slave call
    int          s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs, s_viol, s_cyc;
    logic        s_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;

    axil_lite_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write), .busy(busy), .err_timeout(err_timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    endtask

    // Present a command at the current negedge; returns one cycle later
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Slave responder: latencies count cycles a VALID waits before READY (or
    // before the slave raises B/RVALID after the address/data handshakes).
    task automatic run_slave(input int aw_lat, input int w_lat, input int b_lat,
                             input int ar_lat, input int r_lat,
                             input logic [1:0] bresp_v, input logic [1:0] rresp_v,
                             input logic [31:0] rdata_v);
        int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0;
        logic aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0;
        logic aw_hold = 0, w_hold = 0, ar_hold = 0;
        logic [31:0] aw_ref = 0, ar_ref = 0;
        logic [35:0] w_ref = 0;
        s_aw_hs = 0; s_w_hs = 0; s_b_hs = 0; s_ar_hs = 0; s_r_hs = 0;
        s_viol = 0; s_cyc = 0; s_got = 0;
        s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
        while (s_cyc < 60 && !s_got) begin
            if (rsp_valid === 1'b1) begin
                s_got = 1'b1;
                clear_slave();
            end else begin
                // B and R first so they follow the earlier handshakes by a cycle
                if (aw_done && w_done && !b_done) begin
                    bvalid = (b_w >= b_lat);
                    bresp  = bresp_v;
                    if (bvalid && bready) begin s_b_hs++; b_done = 1'b1; end
                    else b_w++;
                end else bvalid = 1'b0;
                if (ar_done && !r_done) begin
                    rvalid = (r_w >= r_lat);
                    rdata  = rdata_v;
                    rresp  = rresp_v;
                    if (rvalid && rready) begin s_r_hs++; r_done = 1'b1; end
                    else r_w++;
                end else rvalid = 1'b0;
                if (awvalid) begin
                    if (aw_hold && awaddr !== aw_ref) s_viol++;
                    aw_ref = awaddr; aw_hold = 1'b1;
                    awready = (aw_w >= aw_lat);
                    if (awready) begin s_aw_hs++; s_awaddr = awaddr; aw_done = 1'b1; aw_hold = 1'b0; aw_w = 0; end
                    else aw_w++;
                end else begin
                    if (aw_hold) s_viol++;
                    awready = 1'b0;
                end
                if (wvalid) begin
                    if (w_hold && {wstrb, wdata} !== w_ref) s_viol++;
                    w_ref = {wstrb, wdata}; w_hold = 1'b1;
                    wready = (w_w >= w_lat);
                    if (wready) begin s_w_hs++; s_wdata = wdata; s_wstrb = wstrb; w_done = 1'b1; w_hold = 1'b0; w_w = 0; end
                    else w_w++;
                end else begin
                    if (w_hold) s_viol++;
                    wready = 1'b0;
                end
                if (arvalid) begin
                    if (ar_hold && araddr !== ar_ref) s_viol++;
                    ar_ref = araddr; ar_hold = 1'b1;
                    arready = (ar_w >= ar_lat);
                    if (arready) begin s_ar_hs++; s_araddr = araddr; ar_done = 1'b1; ar_hold = 1'b0; ar_w = 0; end
                    else ar_w++;
                end else begin
                    if (ar_hold) s_viol++;
                    arready = 1'b0;
                end
                @(negedge clk);
                s_cyc++;
            end
        end
        clear_slave();
    endtask

    // Accept the pending response and return to the following negedge
    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, err_timeout} !== 7'b0) begin
            n_fail++; $display("FAIL reset_valids got=%b exp=0000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, err_timeout});
        end
        n_checks++;
        if ({awaddr, wdata, wstrb, rsp_rdata, rsp_resp} !== 102'b0) begin
            n_fail++; $display("FAIL reset_data got=%h exp=0", {awaddr, wdata, wstrb, rsp_rdata, rsp_resp});
        end
    endtask

    task automatic test_write_basic();
        issue(1'b1, 32'h0, 32'h0000_00A5, 4'hF);
        run_slave(1, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        n_checks++; if (s_got !== 1'b1) begin n_fail++; $display("FAIL wr_basic_rsp got=%b exp=1", s_got); end
        n_checks++; if (s_cyc !== 3) begin n_fail++; $display("FAIL wr_basic_latency got=%0d exp=3", s_cyc); end
        n_checks++;
        if ({s_aw_hs, s_w_hs, s_b_hs, s_ar_hs} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
            n_fail++; $display("FAIL wr_basic_hs got aw=%0d w=%0d b=%0d ar=%0d exp 1/1/1/0", s_aw_hs, s_w_hs, s_b_hs, s_ar_hs);
        end
        n_checks++;
        if ({s_awaddr, s_wdata, s_wstrb} !== {32'h0, 32'h0000_00A5, 4'hF}) begin
            n_fail++; $display("FAIL wr_basic_beat got addr=%h data=%h strb=%h exp 0/000000a5/f", s_awaddr, s_wdata, s_wstrb);
        end
        n_checks++;
        if ({rsp_resp, rsp_write, rsp_rdata} !== {2'b00, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wr_basic_rsp_fields got resp=%b wr=%b rdata=%h exp 00/1/0", rsp_resp, rsp_write, rsp_rdata);
        end
        consume();
        n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL wr_basic_idle got=%b exp=01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_write_w_first();
        issue(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'h5);
        run_slave(3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        n_checks++; if (s_cyc !== 5) begin n_fail++; $display("FAIL wr_wfirst_latency got=%0d exp=5", s_cyc); end
        n_checks++;
        if ({s_aw_hs, s_w_hs, s_b_hs} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL wr_wfirst_hs got aw=%0d w=%0d b=%0d exp 1/1/1", s_aw_hs, s_w_hs, s_b_hs);
        end
        n_checks++; if (s_viol !== 0) begin n_fail++; $display("FAIL wr_wfirst_stable got=%0d exp=0", s_viol); end
        n_checks++;
        if ({s_awaddr, s_wdata, s_wstrb} !== {32'h8, 32'hCAFE_F00D, 4'h5}) begin
            n_fail++; $display("FAIL wr_wfirst_beat got addr=%h data=%h strb=%h exp 8/cafef00d/5", s_awaddr, s_wdata, s_wstrb);
        end
        consume();
    endtask

    task automatic test_read();
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        run_slave(0, 0, 0, 0, 2, 2'b00, 2'b00, 32'h0000_00A5);
        n_checks++; if (s_cyc !== 4) begin n_fail++; $display("FAIL rd_latency got=%0d exp=4", s_cyc); end
        n_checks++;
        if ({s_ar_hs, s_r_hs, s_aw_hs, s_w_hs} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL rd_hs got ar=%0d r=%0d aw=%0d w=%0d exp 1/1/0/0", s_ar_hs, s_r_hs, s_aw_hs, s_w_hs);
        end
        n_checks++;
        if ({rsp_rdata, rsp_resp, rsp_write} !== {32'h0000_00A5, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL rd_rsp got rdata=%h resp=%b wr=%b exp 000000a5/00/0", rsp_rdata, rsp_resp, rsp_write);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        run_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hDEAD_BEEF);
        n_checks++; if (s_cyc !== 2) begin n_fail++; $display("FAIL b2b_rd_latency got=%0d exp=2", s_cyc); end
        n_checks++; if (s_araddr !== 32'h10) begin n_fail++; $display("FAIL b2b_araddr got=%h exp=10", s_araddr); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00 || cmd_ready !== 1'b0 ||
                {awvalid, wvalid, bready, arvalid, rready} !== 5'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_hold bad_cycles got=%0d exp=0", bad); end
        consume();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
        issue(1'b1, 32'h0000_0014, 32'h1234_5678, 4'h3);
        run_slave(0, 0, 0, 0, 0, 2'b11, 2'b00, 32'h0);
        n_checks++; if (s_cyc !== 2) begin n_fail++; $display("FAIL b2b_wr_latency got=%0d exp=2", s_cyc); end
        n_checks++;
        if ({s_awaddr, s_wdata, s_wstrb} !== {32'h14, 32'h1234_5678, 4'h3}) begin
            n_fail++; $display("FAIL b2b_wr_beat got addr=%h data=%h strb=%h exp 14/12345678/3", s_awaddr, s_wdata, s_wstrb);
        end
        n_checks++;
        if ({rsp_resp, rsp_write, rsp_rdata} !== {2'b11, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL b2b_wr_rsp got resp=%b wr=%b rdata=%h exp 11/1/0", rsp_resp, rsp_write, rsp_rdata);
        end
        consume();
    endtask

    task automatic test_slave_error();
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        run_slave(0, 0, 0, 1, 0, 2'b00, 2'b10, 32'hBAD0_BAD0);
        n_checks++;
        if ({rsp_resp, rsp_rdata} !== {2'b10, 32'hBAD0_BAD0}) begin
            n_fail++; $display("FAIL slverr_rsp got resp=%b rdata=%h exp 10/bad0bad0", rsp_resp, rsp_rdata);
        end
        consume();
        n_checks++; if ({busy, cmd_ready, err_timeout} !== 3'b010) begin n_fail++; $display("FAIL slverr_idle got=%b exp=010", {busy, cmd_ready, err_timeout}); end
    endtask

    task automatic test_timeout_reset();
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        // ARVALID rose at this negedge; slave never asserts ARREADY
        for (int i = 0; i < 15; i++) @(negedge clk);
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early got=%b exp=0", err_timeout); end
        @(negedge clk);
        n_checks++; if ({err_timeout, arvalid} !== 2'b11) begin n_fail++; $display("FAIL wd_fire got err/arvalid=%b exp=11", {err_timeout, arvalid}); end
        for (int i = 0; i < 3; i++) @(negedge clk);
        n_checks++; if ({err_timeout, arvalid, araddr} !== {2'b11, 32'h20}) begin n_fail++; $display("FAIL wd_sticky got=%h exp=3_00000020", {err_timeout, arvalid, araddr}); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({arvalid, err_timeout, busy} !== 3'b000) begin n_fail++; $display("FAIL async_rst got=%b exp=000", {arvalid, err_timeout, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({cmd_ready, arvalid, err_timeout} !== 3'b100) begin n_fail++; $display("FAIL post_rst got=%b exp=100", {cmd_ready, arvalid, err_timeout}); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1'b0;
        clear_slave();
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_write_basic();
        test_write_w_first();
        test_read();
        test_back_to_back();
        test_slave_error();
        test_timeout_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
